// File: rtl/writeback_sched_if.sv
// Write-back scheduler bus: the four write-back requesters on one side and the
// register-file write port plus status on the other.
interface writeback_sched_if;
  logic       alu_req;
  logic [4:0] alu_dest;
  logic       load_req;
  logic       load_ext;
  logic [4:0] load_dest;
  logic       jal_req;
  logic       exc_req;
  logic [3:0] grant;
  logic       mem_read;
  logic [3:0] wd_sel;
  logic       reg_write;
  logic [4:0] write_reg;
  logic       load_abort;
  logic       busy;
  logic [7:0] wb_count;

  // Requesters / environment side.
  modport master (
    output alu_req, alu_dest, load_req, load_ext, load_dest, jal_req, exc_req,
    input  grant, mem_read, wd_sel, reg_write, write_reg, load_abort, busy,
           wb_count
  );

  // Scheduler side.
  modport slave (
    input  alu_req, alu_dest, load_req, load_ext, load_dest, jal_req, exc_req,
    output grant, mem_read, wd_sel, reg_write, write_reg, load_abort, busy,
           wb_count
  );
endinterface

// File: rtl/writeback_sched.sv
// Write-back scheduler: arbitrates ALU, load, link and exception results onto a
// single register-file write port. Loads take two memory cycles before their
// write; an exception arriving during those cycles cancels the load and takes
// over the write slot.
module writeback_sched (
  input  logic              clk,
  input  logic              reset,
  writeback_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM1  = 2'd1,
    MEM2  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Write-data mux selector codes.
  typedef enum logic [2:0] {
    SEL_ALU  = 3'd0,
    SEL_WORD = 3'd1,
    SEL_EXT  = 3'd2,
    SEL_JAL  = 3'd3,
    SEL_EXC  = 3'd4
  } sel_t;

  localparam logic [4:0] JAL_DEST = 5'd31;
  localparam logic [4:0] EXC_DEST = 5'd27;

  state_t     state, state_nxt;
  sel_t       code, code_nxt;
  logic [4:0] dest, dest_nxt;
  logic [7:0] wb_count;
  logic [3:0] grant_raw;
  logic       abort_raw;
  logic       in_mem;
  logic       in_write;

  // State and latched write descriptor.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state <= IDLE;
      code  <= SEL_ALU;
      dest  <= '0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      dest  <= dest_nxt;
    end
  end

  // Completed-write counter, wraps silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_count <= '0;
    end else if (state == WRITE) begin
      wb_count <= wb_count + 8'd1;
    end
  end

  // Arbitration, load cancellation and next-state selection.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    code_nxt  = code;
    dest_nxt  = dest;
    grant_raw = '0;
    abort_raw = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.exc_req) begin
          grant_raw = 4'b1000;
          code_nxt  = SEL_EXC;
          dest_nxt  = EXC_DEST;
          state_nxt = WRITE;
        end else if (bus.jal_req) begin
          grant_raw = 4'b0100;
          code_nxt  = SEL_JAL;
          dest_nxt  = JAL_DEST;
          state_nxt = WRITE;
        end else if (bus.load_req) begin
          grant_raw = 4'b0010;
          code_nxt  = bus.load_ext ? SEL_EXT : SEL_WORD;
          dest_nxt  = bus.load_dest;
          state_nxt = MEM1;
        end else if (bus.alu_req) begin
          grant_raw = 4'b0001;
          code_nxt  = SEL_ALU;
          dest_nxt  = bus.alu_dest;
          state_nxt = WRITE;
        end
      end
      MEM1, MEM2: begin
        if (bus.exc_req) begin
          // Exception steals the slot; the load's write never happens.
          grant_raw = 4'b1000;
          abort_raw = 1'b1;
          code_nxt  = SEL_EXC;
          dest_nxt  = EXC_DEST;
          state_nxt = WRITE;
        end else begin
          state_nxt = (state == MEM1) ? MEM2 : WRITE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_mem   = (state == MEM1) || (state == MEM2);
  assign in_write = (state == WRITE);

  // While reset is low nothing is granted, aborted, read or written, so an
  // operation caught by reset leaves no trace.
  assign bus.grant      = reset ? grant_raw : 4'b0000;
  assign bus.load_abort = reset & abort_raw;
  assign bus.mem_read   = reset & in_mem & ~bus.exc_req;
  assign bus.reg_write  = reset & in_write;
  assign bus.wd_sel     = bus.reg_write ? {1'b0, code} : 4'd0;
  assign bus.write_reg  = bus.reg_write ? dest : 5'd0;
  assign bus.busy       = (state != IDLE);
  assign bus.wb_count   = wb_count;

endmodule
